// File: rtl/fre_detect.sv
// fre_detect: measures the period of the asynchronous input `test` in clk cycles
// and asserts `d` once LOCK_COUNT consecutive periods fall inside
// [MIN_PERIOD, MAX_PERIOD]. A missing edge (timeout) or an out-of-window
// period drops the lock.
module fre_detect #(
  parameter int CNT_W       = 16,
  parameter int MIN_PERIOD  = 18,
  parameter int MAX_PERIOD  = 22,
  parameter int LOCK_COUNT  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic test,
  output logic d
);

  localparam int LW = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] CNT_TOUT = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W:0]   MIN_P    = (CNT_W + 1)'(MIN_PERIOD);
  localparam logic [CNT_W:0]   MAX_P    = (CNT_W + 1)'(MAX_PERIOD);
  localparam logic [LW-1:0]    LOCK_MAX = LW'(LOCK_COUNT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   edge_reg;
  logic                   rise;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W:0]         period;
  logic                   timeout;
  logic [LW-1:0]          lock_cnt;
  logic [LW-1:0]          lock_nxt;
  logic                   first_seen;
  logic                   first_nxt;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~edge_reg;
  // Period includes the cycle of the rise itself, so rises 20 cycles apart give 20.
  assign period   = {1'b0, cnt} + (CNT_W + 1)'(1);
  // No rise by the time the period would exceed MAX_PERIOD.
  assign timeout  = (cnt >= CNT_TOUT);

  // Synchronizer chain and edge register for the asynchronous input.
  // NOTE: every register here uses non-blocking assignment so all stages sample
  // the pre-edge values; blocking would collapse the chain into one flop.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: only control state exists here, so everything is cleared by the
    // asynchronous reset; there is no storage array that could skip reset.
    if (!rst) begin
      sync_q   <= '0;
      edge_reg <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], test};
      edge_reg <= sync_out;
    end
  end

  // Period counter: restarts on each detected rise, saturates otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= '0;
    end else if (cnt != CNT_SAT) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Next-state logic for the lock counter and first-edge flag.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch forms.
    lock_nxt  = lock_cnt;
    first_nxt = first_seen;
    if (rise) begin
      if (first_seen) begin
        if (period >= MIN_P && period <= MAX_P) begin
          lock_nxt = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + LW'(1);
        end else begin
          lock_nxt = '0;
        end
      end else begin
        // First edge only opens a measurement window.
        first_nxt = 1'b1;
      end
    end else if (timeout) begin
      lock_nxt  = '0;
      first_nxt = 1'b0;
    end
  end

  // Lock state and registered detect output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_cnt   <= '0;
      first_seen <= 1'b0;
      d          <= 1'b0;
    end else begin
      lock_cnt   <= lock_nxt;
      first_seen <= first_nxt;
      d          <= (lock_nxt == LOCK_MAX);
    end
  end

endmodule

// File: tb/tb_fre_detect.sv
// tb_fre_detect: drives `test` with directed and random period sequences and
// compares `d` every cycle against a model that works on rise times and
// period lengths in clk cycles.
`timescale 1ns/1ps
module tb_fre_detect;

  localparam int CNT_W       = 16;
  localparam int MIN_PERIOD  = 18;
  localparam int MAX_PERIOD  = 22;
  localparam int LOCK_COUNT  = 4;
  localparam int SYNC_STAGES = 2;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic test = 1'b0;
  logic d;

  int n_tests = 0;
  int n_fail  = 0;

  fre_detect #(
    .CNT_W      (CNT_W),
    .MIN_PERIOD (MIN_PERIOD),
    .MAX_PERIOD (MAX_PERIOD),
    .LOCK_COUNT (LOCK_COUNT),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .test(test),
    .d   (d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: d=%b expected %b at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model: a rise of `test` seen at a clk edge is reported SYNC_STAGES
  // edges later; periods are differences between reported rise edge numbers.
  bit dly[$];
  bit prev_test = 1'b0;
  int edge_no   = 0;
  int last_rise = 0;
  bit have_ref  = 1'b0;
  int streak    = 0;
  bit exp_d     = 1'b0;

  initial begin
    repeat (SYNC_STAGES) dly.push_back(1'b0);
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        dly.delete();
        repeat (SYNC_STAGES) dly.push_back(1'b0);
        prev_test = 1'b0;
        edge_no   = 0;
        last_rise = 0;
        have_ref  = 1'b0;
        streak    = 0;
        exp_d     = 1'b0;
      end else begin
        bit r;
        edge_no++;
        dly.push_back(test & ~prev_test);
        prev_test = test;
        r = dly.pop_front();
        if (r) begin
          if (have_ref) begin
            int gap;
            gap = edge_no - last_rise;
            if (gap >= MIN_PERIOD && gap <= MAX_PERIOD)
              streak = (streak < LOCK_COUNT) ? streak + 1 : LOCK_COUNT;
            else
              streak = 0;
          end else begin
            have_ref = 1'b1;
          end
          last_rise = edge_no;
        end else if (have_ref && (edge_no - last_rise) > MAX_PERIOD) begin
          streak   = 0;
          have_ref = 1'b0;
        end
        exp_d = (streak == LOCK_COUNT);
      end
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("d_cycle", d, exp_d);
    end
  end

  task automatic hold(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic period(input int hi, input int lo);
    test = 1'b1;
    hold(hi);
    test = 1'b0;
    hold(lo);
  endtask

  task automatic lock_up();
    repeat (6) period(10, 10);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("async_reset", d, 1'b0);
    hold(3);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #12 rst = 1'b1;
    @(negedge clk);

    // Steady 20-cycle period locks.
    check("reset_state", d, 1'b0);
    repeat (8) period(10, 10);
    check("s1_lock", d, 1'b1);

    // One 30-cycle period times out, then relock.
    period(15, 15);
    hold(5);
    check("s2_timeout", d, 1'b0);
    repeat (7) period(10, 10);
    check("s2_relock", d, 1'b1);

    // Boundary periods 18 and 22 keep lock.
    period(9, 9);
    period(11, 11);
    period(10, 10);
    check("s3_bound_ok", d, 1'b1);
    // 17 is rejected.
    period(8, 9);
    period(10, 10);
    check("s3_p17", d, 1'b0);
    lock_up();
    check("s3_relock", d, 1'b1);
    // 23 is rejected.
    period(11, 12);
    period(10, 10);
    check("s3_p23", d, 1'b0);

    // Constant input after lock: drops and never relocks.
    lock_up();
    check("s4_locked", d, 1'b1);
    hold(40);
    check("s4_low", d, 1'b0);
    test = 1'b1;
    hold(40);
    check("s4_high", d, 1'b0);
    test = 1'b0;
    hold(5);

    // Reset while locked.
    lock_up();
    check("s5_locked", d, 1'b1);
    pulse_reset();
    lock_up();
    check("s5_relock", d, 1'b1);

    // Asymmetric duty cycle still locks.
    test = 1'b0;
    hold(30);
    repeat (8) period(5, 15);
    check("s6_duty", d, 1'b1);

    // Random period sequences.
    for (int i = 0; i < 300; i++) begin
      int sel;
      int p;
      int hi;
      sel = $urandom_range(99);
      if (sel < 60)      p = $urandom_range(MAX_PERIOD, MIN_PERIOD);
      else if (sel < 75) p = $urandom_range(MIN_PERIOD - 1, MIN_PERIOD - 6);
      else if (sel < 90) p = $urandom_range(MAX_PERIOD + 4, MAX_PERIOD + 1);
      else               p = $urandom_range(60, 30);
      hi = $urandom_range(p - 1, 1);
      period(hi, p - hi);
      if ($urandom_range(99) == 0) pulse_reset();
    end

    hold(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
